mux_sched_ctrl: RTL
===================

Name: mux_sched_ctrl

Overview:
Scheduler that sequences the 4:1 operand mux in the matrix block multiplier. On a start command it walks select 0→3 for a programmed number of passes. Each selected 16-bit operand is presented to the downstream MAC/accumulator stage through a registered valid/ready output, with a per-pass last tag. It replaces free-running select generation with a start/busy/done handshake and backpressure support.

Parameters:
DATA_W, 16, operand width (input_1..input_4, out).
PASS_W, 4, width of the pass-count field; max passes = 2^PASS_W-1.

Ports:
clock  input  1  single clock, rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
start  input  1  start command; sampled only in IDLE.
num_passes  input  PASS_W  number of 4-operand passes; latched on accepted start.
ready  input  1  downstream accepts the current beat.
input_1  input  DATA_W  operand for select 0.
input_2  input  DATA_W  operand for select 1.
input_3  input  DATA_W  operand for select 2.
input_4  input  DATA_W  operand for select 3.
select  output  2  index of the operand currently held in out.
out  output  DATA_W  registered selected operand.
out_valid  output  1  out/select/last hold a valid beat.
last  output  1  current beat is select 3 (end of a pass).
busy  output  1  high in RUN and DRAIN.
done  output  1  one-cycle pulse at end of command.

Behaviour:
- Reset (reset=0, async): state IDLE; select=0, out=0, out_valid=0, last=0, busy=0, done=0; sel_cnt=0, pass_cnt=0, latched count=0.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 and num_passes≠0 → latch num_passes, clear sel_cnt and pass_cnt, go to RUN.
  - start=1 and num_passes=0 → go to DONE; no beats are produced.
- RUN, load rule: when (!out_valid || ready), on the clock edge:
  - out ← input[sel_cnt] (input_1 for sel_cnt=0, …, input_4 for sel_cnt=3), sampled that edge;
  - select ← sel_cnt; last ← (sel_cnt==3); out_valid ← 1;
  - sel_cnt increments, wrapping 3→0; on wrap, pass_cnt increments.
- RUN, exit: the edge that loads sel_cnt=3 with pass_cnt = latched−1 moves the FSM to DRAIN. No further loads occur.
- Backpressure: while out_valid=1 and ready=0, out/select/last hold stable. Beats are never skipped or duplicated.
- DRAIN: out_valid=1 and ready=1 → out_valid ← 0, last ← 0, go to DONE. Otherwise hold.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Timing with ready tied high, start sampled at edge E0:
  - beat k is valid after edge E(k+1), for k=0..4N−1;
  - done is high in the cycle after E(4N+1).
- Throughput: 1 beat/cycle while ready=1.
- start while not in IDLE is ignored. num_passes changes after latching are ignored.
- Counters are unsigned. pass_cnt is PASS_W bits and never overflows, because exit occurs at latched−1.
- Reset asserted mid-command clears all state immediately. No done pulse is produced. A new start after reset release behaves normally.

Decomposition:
- Package mux_sched_pkg holds:
  - state encoding: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, DONE=2'd3;
  - SEL_W=2, NUM_IN=4, LAST_SEL=2'd3.
- Sub-module sched_counter (the natural split): sel_cnt/pass_cnt with enable, clear, wrap flag and terminal flag. FSM, operand selection and output register stay in mux_sched_ctrl.

Test Plan:
- Common stimulus: input_1..4 = 16'h0300, 16'h0200, 16'h0100, 16'h0000.
- Reset, then start with num_passes=1 and ready=1 → out = 0300, 0200, 0100, 0000 after E1..E4; select = 0,1,2,3; last only on 0000; done one cycle after E5; busy high E0..E5.
- num_passes=2, ready=1 → 8 beats, sequence repeated twice; last high on beats 4 and 8; exactly one done pulse.
- num_passes=1, ready=0 for 3 cycles while out=0200 → out=0200 and select=1 held stable; next beat is 0100; total 4 beats, none lost or duplicated.
- start with num_passes=0 → out_valid never asserts; done pulses the cycle after start is sampled; busy stays 0.
- reset driven 0 during pass 1, select=2 → all outputs 0 immediately, no done; after release, start with num_passes=1 yields the full 4-beat sequence.
- start pulsed and num_passes changed to 5 during RUN of a 1-pass command → ignored; exactly 4 beats, then done.

Source files
------------

// File: rtl/mux_sched_pkg.sv
// Shared encodings for the operand-mux scheduler: FSM states and select-counter geometry.
package mux_sched_pkg;

    localparam int          SEL_W    = 2;
    localparam int          NUM_IN   = 4;
    localparam logic [1:0]  LAST_SEL = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/sched_counter.sv
// Select/pass counter pair for the operand scheduler, with wrap and terminal flags.
module sched_counter
    import mux_sched_pkg::*;
#(
    parameter int PASS_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr,
    input  logic              en,
    input  logic [PASS_W-1:0] pass_last,
    output logic [SEL_W-1:0]  sel_cnt,
    output logic              wrap,
    output logic              terminal
);

    logic [PASS_W-1:0] pass_cnt;

    assign wrap     = (sel_cnt == LAST_SEL);
    assign terminal = wrap && (pass_cnt == pass_last);

    // sel_cnt is exactly SEL_W bits wide, so 3 -> 0 wraps on its own.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_cnt  <= '0;
            pass_cnt <= '0;
        end else if (clr) begin
            sel_cnt  <= '0;
            pass_cnt <= '0;
        end else if (en) begin
            sel_cnt <= sel_cnt + SEL_W'(1);
            if (wrap) begin
                pass_cnt <= pass_cnt + PASS_W'(1);
            end
        end
    end

endmodule

// File: rtl/mux_sched_ctrl.sv
// Sequences the 4:1 operand mux for a programmed number of passes into a registered valid/ready beat stream.
//   state | meaning
//   IDLE  | waiting for start; counters parked
//   RUN   | loading one operand per accepted beat
//   DRAIN | final beat (select 3 of last pass) waiting to be accepted
//   DONE  | one-cycle done pulse, then back to IDLE
module mux_sched_ctrl
    import mux_sched_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int PASS_W = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [PASS_W-1:0] num_passes,
    input  logic              ready,
    input  logic [DATA_W-1:0] input_1,
    input  logic [DATA_W-1:0] input_2,
    input  logic [DATA_W-1:0] input_3,
    input  logic [DATA_W-1:0] input_4,
    output logic [SEL_W-1:0]  select,
    output logic [DATA_W-1:0] out,
    output logic              out_valid,
    output logic              last,
    output logic              busy,
    output logic              done
);

    sched_state_t      state;
    logic [PASS_W-1:0] num_lat;
    logic [SEL_W-1:0]  sel_cnt;
    logic              wrap;
    logic              terminal;
    logic              load;
    logic              cnt_clr;
    logic [DATA_W-1:0] operand;

    assign load    = (state == RUN) && (!out_valid || ready);
    assign cnt_clr = (state == IDLE) && start && (num_passes != '0);

    sched_counter #(.PASS_W(PASS_W)) u_cnt (
        .clock     (clock),
        .reset     (reset),
        .clr       (cnt_clr),
        .en        (load),
        .pass_last (num_lat - PASS_W'(1)),
        .sel_cnt   (sel_cnt),
        .wrap      (wrap),
        .terminal  (terminal)
    );

    always_comb begin
        operand = input_1;
        case (sel_cnt)
            2'd0:    operand = input_1;
            2'd1:    operand = input_2;
            2'd2:    operand = input_3;
            2'd3:    operand = input_4;
            default: operand = input_1;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            num_lat   <= '0;
            select    <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            last      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_passes != '0) begin
                            num_lat <= num_passes;
                            busy    <= 1'b1;
                            state   <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        out       <= operand;
                        select    <= sel_cnt;
                        last      <= wrap;
                        out_valid <= 1'b1;
                        if (terminal) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && ready) begin
                        out_valid <= 1'b0;
                        last      <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
